// File: rtl/plotter_pkg.sv
// Shared definitions for the raster plot sequencer.
//   state_t            : sequencer state, 4-bit encoding mirrored on state_out
//   AXIS_X / AXIS_Y    : step_axis_out values
//   DIR_POS / DIR_NEG  : step_dir_out values (1 = positive)
//   width_of()         : bit width for an index range, never less than 1
package plotter_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_PEN_DN  = 4'd2,
        ST_PEN_UP  = 4'd3,
        ST_ADVANCE = 4'd4,
        ST_STEP_X  = 4'd5,
        ST_STEP_Y  = 4'd6,
        ST_FINISH  = 4'd7
    } state_t;

    localparam logic AXIS_X  = 1'b0;
    localparam logic AXIS_Y  = 1'b1;
    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

    // Index width for a range of n values; a single-row image still gets a 1-bit index.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step_burst.sv
// Issues a burst of stepper handshakes on one axis.
//   clk, rst      : clock, asynchronous active-high reset
//   go            : one-cycle pulse; latches count/axis/dir and starts the burst
//   count         : number of steps in the burst
//   axis, dir     : axis and direction for every step of the burst
//   abort         : level; stops the burst at the next step boundary
//   step_done     : driver finished the current step (ignored while step_req is low)
//   step_req      : step request level, held until step_done
//   step_axis     : latched axis, stable for the whole burst
//   step_dir      : latched direction, stable for the whole burst
//   burst_done    : one-cycle pulse once the burst has ended (complete or aborted)
module step_burst #(
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [COUNT_W-1:0] count,
    input  logic               axis,
    input  logic               dir,
    input  logic               abort,
    input  logic               step_done,
    output logic               step_req,
    output logic               step_axis,
    output logic               step_dir,
    output logic               burst_done
);

    logic               active;
    logic [COUNT_W-1:0] remaining;

    // NOTE: registered state uses non-blocking assignments so every branch
    // sees the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active     <= 1'b0;
            step_req   <= 1'b0;
            step_axis  <= 1'b0;
            step_dir   <= 1'b0;
            remaining  <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            if (!active) begin
                if (go) begin
                    active    <= 1'b1;
                    step_req  <= 1'b1;
                    remaining <= count;
                    step_axis <= axis;
                    step_dir  <= dir;
                end
            end else if (step_req) begin
                // A started step always runs to completion, even under abort.
                if (step_done) begin
                    step_req  <= 1'b0;
                    remaining <= remaining - 1'b1;
                    if (remaining == COUNT_W'(1) || abort) begin
                        active     <= 1'b0;
                        burst_done <= 1'b1;
                    end
                end
            end else begin
                // Mandatory low cycle between steps; abort can end the burst here.
                if (abort) begin
                    active     <= 1'b0;
                    burst_done <= 1'b1;
                end else begin
                    step_req <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/raster_plot_sequencer.sv
// Walks a raster image in serpentine order, dropping the pen on marked pixels
// and stepping the X/Y carriage between pixels.
//   clk_100mhz, rst_in          : clock, asynchronous active-high reset
//   start_in, abort_in          : one-cycle command pulses
//   pixel_req_out/x/y           : pixel fetch request and its coordinates
//   pixel_valid_in/value_in     : pixel response (1 = mark)
//   step_req_out/axis/dir       : stepper handshake to the drivers
//   step_done_in                : driver step completion
//   pen_down_out                : pen solenoid command
//   busy_out, done_out          : activity level and end-of-plot pulse
//   state_out                   : current state encoding for LEDs
module raster_plot_sequencer
    import plotter_pkg::*;
#(
    parameter int IMG_W             = 64,
    parameter int IMG_H             = 64,
    parameter int STEPS_PER_PIXEL   = 8,
    parameter int PEN_SETTLE_CYCLES = 5_000_000
) (
    input  logic                       clk_100mhz,
    input  logic                       rst_in,
    input  logic                       start_in,
    input  logic                       abort_in,
    output logic                       pixel_req_out,
    output logic [width_of(IMG_W)-1:0] pixel_x_out,
    output logic [width_of(IMG_H)-1:0] pixel_y_out,
    input  logic                       pixel_valid_in,
    input  logic                       pixel_value_in,
    output logic                       step_req_out,
    output logic                       step_axis_out,
    output logic                       step_dir_out,
    input  logic                       step_done_in,
    output logic                       pen_down_out,
    output logic                       busy_out,
    output logic                       done_out,
    output logic [3:0]                 state_out
);

    localparam int XW      = width_of(IMG_W);
    localparam int YW      = width_of(IMG_H);
    localparam int DWELL_W = $clog2(PEN_SETTLE_CYCLES + 1);
    localparam int STEP_W  = $clog2(STEPS_PER_PIXEL + 1);

    localparam logic [XW-1:0]      X_LAST     = XW'(IMG_W - 1);
    localparam logic [YW-1:0]      Y_LAST     = YW'(IMG_H - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(PEN_SETTLE_CYCLES - 1);
    localparam logic [STEP_W-1:0]  STEP_COUNT = STEP_W'(STEPS_PER_PIXEL);

    state_t             state;
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic               dir;
    logic               abort_pending;
    logic [DWELL_W-1:0] dwell;

    logic abort_any;
    logic row_end;
    logic burst_go;
    logic burst_axis;
    logic burst_dir;
    logic burst_done;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        abort_any  = abort_in | abort_pending;
        row_end    = (dir == DIR_POS) ? (x == X_LAST) : (x == '0);
        burst_go   = 1'b0;
        burst_axis = AXIS_X;
        burst_dir  = dir;
        // The burst is launched from the ADVANCE decision so its request
        // rises on the same edge that enters STEP_X/STEP_Y.
        if (state == ST_ADVANCE && !abort_any) begin
            if (!row_end) begin
                burst_go = 1'b1;
            end else if (y != Y_LAST) begin
                burst_go   = 1'b1;
                burst_axis = AXIS_Y;
                burst_dir  = DIR_POS;
            end
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) begin
            state         <= ST_IDLE;
            x             <= '0;
            y             <= '0;
            dir           <= DIR_POS;
            abort_pending <= 1'b0;
            dwell         <= '0;
        end else begin
            // Abort is remembered until FINISH so handshakes in flight can complete.
            if (abort_in && state != ST_IDLE && state != ST_FINISH)
                abort_pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        x     <= '0;
                        y     <= '0;
                        dir   <= DIR_POS;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (pixel_valid_in) begin
                        if (abort_any) begin
                            state <= ST_FINISH;
                        end else if (pixel_value_in) begin
                            dwell <= '0;
                            state <= ST_PEN_DN;
                        end else begin
                            state <= ST_ADVANCE;
                        end
                    end
                end
                ST_PEN_DN: begin
                    if (abort_any) begin
                        state <= ST_FINISH;
                    end else if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        state <= ST_PEN_UP;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                ST_PEN_UP: begin
                    if (abort_any) begin
                        state <= ST_FINISH;
                    end else if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        state <= ST_ADVANCE;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                ST_ADVANCE: begin
                    if (abort_any)             state <= ST_FINISH;
                    else if (!row_end)         state <= ST_STEP_X;
                    else if (y != Y_LAST)      state <= ST_STEP_Y;
                    else                       state <= ST_FINISH;
                end
                ST_STEP_X: begin
                    if (burst_done) begin
                        if (abort_any) begin
                            state <= ST_FINISH;
                        end else begin
                            x     <= (dir == DIR_POS) ? x + 1'b1 : x - 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_STEP_Y: begin
                    if (burst_done) begin
                        if (abort_any) begin
                            state <= ST_FINISH;
                        end else begin
                            // Serpentine: the next row starts at the same column, reversed.
                            y     <= y + 1'b1;
                            dir   <= (dir == DIR_POS) ? DIR_NEG : DIR_POS;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FINISH: begin
                    abort_pending <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    step_burst #(
        .COUNT_W (STEP_W)
    ) u_step_burst (
        .clk        (clk_100mhz),
        .rst        (rst_in),
        .go         (burst_go),
        .count      (STEP_COUNT),
        .axis       (burst_axis),
        .dir        (burst_dir),
        .abort      (abort_any),
        .step_done  (step_done_in),
        .step_req   (step_req_out),
        .step_axis  (step_axis_out),
        .step_dir   (step_dir_out),
        .burst_done (burst_done)
    );

    // Outputs decode directly from the state register, so the asynchronous
    // reset clears them without waiting for a clock edge.
    assign pixel_req_out = (state == ST_FETCH);
    assign pixel_x_out   = x;
    assign pixel_y_out   = y;
    assign pen_down_out  = (state == ST_PEN_DN);
    assign busy_out      = (state != ST_IDLE);
    assign done_out      = (state == ST_FINISH);
    assign state_out     = state;

endmodule

// File: tb/tb_raster_plot_sequencer.sv
// Self-checking bench for raster_plot_sequencer on a 4x2 image with 2 steps
// per pixel and a 3-cycle pen settle. Expected fetch order, step list and pen
// activity come from a serpentine-walk reference model over the image array.
module tb_raster_plot_sequencer;
    import plotter_pkg::*;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int SPP = 2;
    localparam int PEN = 3;

    logic       clk_100mhz = 1'b0;
    logic       rst_in;
    logic       start_in;
    logic       abort_in;
    logic       pixel_req_out;
    logic [1:0] pixel_x_out;
    logic [0:0] pixel_y_out;
    logic       pixel_valid_in;
    logic       pixel_value_in;
    logic       step_req_out;
    logic       step_axis_out;
    logic       step_dir_out;
    logic       step_done_in;
    logic       pen_down_out;
    logic       busy_out;
    logic       done_out;
    logic [3:0] state_out;

    always #5 clk_100mhz = ~clk_100mhz;

    raster_plot_sequencer #(
        .IMG_W             (W),
        .IMG_H             (H),
        .STEPS_PER_PIXEL   (SPP),
        .PEN_SETTLE_CYCLES (PEN)
    ) dut (
        .clk_100mhz     (clk_100mhz),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .abort_in       (abort_in),
        .pixel_req_out  (pixel_req_out),
        .pixel_x_out    (pixel_x_out),
        .pixel_y_out    (pixel_y_out),
        .pixel_valid_in (pixel_valid_in),
        .pixel_value_in (pixel_value_in),
        .step_req_out   (step_req_out),
        .step_axis_out  (step_axis_out),
        .step_dir_out   (step_dir_out),
        .step_done_in   (step_done_in),
        .pen_down_out   (pen_down_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .state_out      (state_out)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    bit img [0:H-1][0:W-1];
    int step_delay = 2;

    // Pixel source: answers a request two cycles after it appears.
    initial begin
        int wait_cnt;
        pixel_valid_in = 1'b0;
        pixel_value_in = 1'b0;
        wait_cnt = 0;
        forever begin
            @(negedge clk_100mhz);
            if (rst_in) begin
                pixel_valid_in = 1'b0;
                pixel_value_in = 1'b0;
                wait_cnt = 0;
            end else if (pixel_valid_in) begin
                pixel_valid_in = 1'b0;
                pixel_value_in = 1'b0;
            end else if (pixel_req_out) begin
                wait_cnt++;
                if (wait_cnt >= 2) begin
                    wait_cnt = 0;
                    pixel_valid_in = 1'b1;
                    pixel_value_in = img[pixel_y_out][pixel_x_out];
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Stepper driver: completes a step step_delay cycles after the request.
    initial begin
        int wait_cnt;
        step_done_in = 1'b0;
        wait_cnt = 0;
        forever begin
            @(negedge clk_100mhz);
            if (rst_in) begin
                step_done_in = 1'b0;
                wait_cnt = 0;
            end else if (step_done_in) begin
                step_done_in = 1'b0;
            end else if (step_req_out) begin
                wait_cnt++;
                if (wait_cnt >= step_delay) begin
                    wait_cnt = 0;
                    step_done_in = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Observed activity.
    int  fetch_q[$];
    int  step_q[$];
    int  pen_run_q[$];
    int  pen_pix_q[$];
    int  done_cnt, dbl_done, pen_up_cycles, stab_err, drop_err, overlap_err;
    int  pen_run, steps_since_fetch, last_fetch;
    logic prev_pix_req, prev_step_req, prev_done, prev_axis, prev_dir, done_at_edge;
    logic [1:0] prev_px;
    logic [0:0] prev_py;

    initial forever begin
        @(posedge clk_100mhz);
        done_at_edge = step_done_in;
    end

    initial begin
        prev_pix_req = 1'b0; prev_step_req = 1'b0; prev_done = 1'b0;
        prev_axis = 1'b0; prev_dir = 1'b0; prev_px = '0; prev_py = '0;
        pen_run = 0; steps_since_fetch = 0; last_fetch = -1;
        forever begin
            @(negedge clk_100mhz);
            if (rst_in) begin
                prev_pix_req = 1'b0; prev_step_req = 1'b0; prev_done = 1'b0;
                pen_run = 0;
            end else begin
                if (pixel_req_out && !prev_pix_req) begin
                    last_fetch = int'(pixel_y_out) * W + int'(pixel_x_out);
                    fetch_q.push_back(last_fetch);
                    steps_since_fetch = 0;
                end
                if (pixel_req_out && prev_pix_req && (pixel_x_out != prev_px || pixel_y_out != prev_py))
                    stab_err++;
                if (step_req_out && !prev_step_req) begin
                    step_q.push_back(int'(step_axis_out) * 2 + int'(step_dir_out));
                    steps_since_fetch++;
                    if (pen_down_out) overlap_err++;
                end
                if (step_req_out && prev_step_req && (step_axis_out != prev_axis || step_dir_out != prev_dir))
                    stab_err++;
                if (!step_req_out && prev_step_req && !done_at_edge)
                    drop_err++;
                if (pen_down_out) begin
                    if (pen_run == 0) begin
                        pen_pix_q.push_back(last_fetch);
                        if (steps_since_fetch != 0) overlap_err++;
                    end
                    pen_run++;
                end else if (pen_run > 0) begin
                    pen_run_q.push_back(pen_run);
                    pen_run = 0;
                end
                if (state_out == ST_PEN_UP) pen_up_cycles++;
                if (done_out) begin
                    done_cnt++;
                    if (prev_done) dbl_done++;
                end
                prev_pix_req  = pixel_req_out;
                prev_step_req = step_req_out;
                prev_done     = done_out;
                prev_axis     = step_axis_out;
                prev_dir      = step_dir_out;
                prev_px       = pixel_x_out;
                prev_py       = pixel_y_out;
            end
        end
    end

    task automatic clear_monitor();
        fetch_q.delete(); step_q.delete(); pen_run_q.delete(); pen_pix_q.delete();
        done_cnt = 0; dbl_done = 0; pen_up_cycles = 0;
        stab_err = 0; drop_err = 0; overlap_err = 0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            @(negedge clk_100mhz);
            cyc++;
        end
        check($sformatf("%s_finished", tag), done_cnt > 0, 1);
        repeat (4) @(negedge clk_100mhz);
    endtask

    // Full plot of the current image, compared with a serpentine-walk model.
    // extra_start: cycle at which a stray start pulse is injected (0 = none).
    task automatic run_plot(input string tag, input int extra_start, input bit abort_with_start);
        int ex_fetch[$];
        int ex_step[$];
        int ex_pen[$];
        int cyc;
        for (int r = 0; r < H; r++)
            for (int k = 0; k < W; k++) begin
                int c = (r % 2 == 0) ? k : W - 1 - k;
                ex_fetch.push_back(r * W + c);
                if (img[r][c]) ex_pen.push_back(r * W + c);
            end
        for (int i = 1; i < ex_fetch.size(); i++)
            for (int s = 0; s < SPP; s++) begin
                if (ex_fetch[i] / W != ex_fetch[i-1] / W) ex_step.push_back(3);           // Y, +
                else ex_step.push_back((ex_fetch[i] > ex_fetch[i-1]) ? 1 : 0);           // X, +/-
            end

        clear_monitor();
        @(negedge clk_100mhz);
        start_in = 1'b1;
        abort_in = abort_with_start;
        @(negedge clk_100mhz);
        start_in = 1'b0;
        abort_in = 1'b0;
        check($sformatf("%s_start_lat", tag), pixel_req_out, 1);
        check($sformatf("%s_busy", tag), busy_out, 1);

        cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            @(negedge clk_100mhz);
            cyc++;
            start_in = (cyc == extra_start);
        end
        start_in = 1'b0;
        check($sformatf("%s_finished", tag), done_cnt > 0, 1);
        repeat (4) @(negedge clk_100mhz);

        check($sformatf("%s_fetch_n", tag), fetch_q.size(), ex_fetch.size());
        for (int i = 0; i < ex_fetch.size() && i < fetch_q.size(); i++)
            check($sformatf("%s_fetch%0d", tag, i), fetch_q[i], ex_fetch[i]);
        check($sformatf("%s_step_n", tag), step_q.size(), ex_step.size());
        for (int i = 0; i < ex_step.size() && i < step_q.size(); i++)
            check($sformatf("%s_step%0d_axdir", tag, i), step_q[i], ex_step[i]);
        check($sformatf("%s_pen_n", tag), pen_pix_q.size(), ex_pen.size());
        for (int i = 0; i < ex_pen.size() && i < pen_pix_q.size(); i++)
            check($sformatf("%s_pen_pix%0d", tag, i), pen_pix_q[i], ex_pen[i]);
        foreach (pen_run_q[i])
            check($sformatf("%s_pen_len%0d", tag, i), pen_run_q[i], PEN);
        check($sformatf("%s_pen_up_cyc", tag), pen_up_cycles, ex_pen.size() * PEN);
        check($sformatf("%s_stable", tag), stab_err, 0);
        check($sformatf("%s_req_drop", tag), drop_err, 0);
        check($sformatf("%s_pen_overlap", tag), overlap_err, 0);
        check($sformatf("%s_done_n", tag), done_cnt, 1);
        check($sformatf("%s_done_width", tag), dbl_done, 0);
        check($sformatf("%s_idle", tag), busy_out, 0);
    endtask

    task automatic set_image(input bit random_fill);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = random_fill ? bit'($urandom_range(1, 0)) : 1'b0;
    endtask

    initial begin
        int cyc;
        rst_in = 1'b1; start_in = 1'b0; abort_in = 1'b0;
        set_image(1'b0);
        clear_monitor();
        repeat (3) @(negedge clk_100mhz);
        check("rst_pen", pen_down_out, 0);
        check("rst_step_req", step_req_out, 0);
        check("rst_pix_req", pixel_req_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_state", state_out, ST_IDLE);
        check("rst_xy", {pixel_y_out, pixel_x_out}, 0);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_100mhz);

        // Blank image: full serpentine walk, no pen activity.
        run_plot("blank", 0, 1'b0);

        // Single mark at (2,0).
        set_image(1'b0);
        img[0][2] = 1'b1;
        run_plot("pix20", 0, 1'b0);

        // Random images.
        for (int k = 0; k < 3; k++) begin
            set_image(1'b1);
            run_plot($sformatf("rand%0d", k), 0, 1'b0);
        end

        // Abort while a step request is outstanding and the driver is slow.
        set_image(1'b0);
        step_delay = 5;
        clear_monitor();
        @(negedge clk_100mhz);
        start_in = 1'b1;
        @(negedge clk_100mhz);
        start_in = 1'b0;
        cyc = 0;
        while (!step_req_out && cyc < 200) begin
            @(negedge clk_100mhz);
            cyc++;
        end
        check("abort_saw_step", step_req_out, 1);
        abort_in = 1'b1;
        @(negedge clk_100mhz);
        abort_in = 1'b0;
        check("abort_req_held", step_req_out, 1);
        wait_done("abort");
        check("abort_step_n", step_q.size(), 1);
        check("abort_fetch_n", fetch_q.size(), 1);
        check("abort_req_drop", drop_err, 0);
        check("abort_done_n", done_cnt, 1);
        check("abort_idle", busy_out, 0);
        check("abort_pen_n", pen_pix_q.size(), 0);
        step_delay = 2;

        // Asynchronous reset while the pen is down.
        set_image(1'b0);
        img[0][0] = 1'b1;
        clear_monitor();
        @(negedge clk_100mhz);
        start_in = 1'b1;
        @(negedge clk_100mhz);
        start_in = 1'b0;
        cyc = 0;
        while (!pen_down_out && cyc < 200) begin
            @(negedge clk_100mhz);
            cyc++;
        end
        check("arst_pen_before", pen_down_out, 1);
        @(posedge clk_100mhz);
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_pen", pen_down_out, 0);
        check("arst_step_req", step_req_out, 0);
        check("arst_pix_req", pixel_req_out, 0);
        check("arst_state", state_out, ST_IDLE);
        repeat (2) @(negedge clk_100mhz);
        rst_in = 1'b0;
        @(negedge clk_100mhz);
        set_image(1'b1);
        run_plot("after_rst", 0, 1'b0);

        // Stray start mid-plot, then start and abort together from IDLE.
        set_image(1'b1);
        run_plot("restart", 12, 1'b0);
        set_image(1'b1);
        run_plot("start_abort", 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
